// File: rtl/alu_uart_frame_ctrl.sv
// Collects NBYTES-wide operands A/B plus an opcode byte from the UART RX stream, then
// returns the ALU result LSB-first over UART TX, with inter-byte timeout and overrun flags.
module alu_uart_frame_ctrl #(
  parameter int NBIT_DATA      = 8,
  parameter int NBYTES         = 2,
  parameter int NBIT_OPCODE    = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          rx_done_tick,
  input  logic [NBIT_DATA-1:0]          rx_data_in,
  input  logic                          tx_done_tick,
  input  logic [NBIT_DATA*NBYTES-1:0]   alu_data_in,
  output logic [NBIT_DATA*NBYTES-1:0]   A,
  output logic [NBIT_DATA*NBYTES-1:0]   B,
  output logic [NBIT_OPCODE-1:0]        OPCODE,
  output logic                          tx_start,
  output logic [NBIT_DATA-1:0]          data_out,
  output logic                          busy,
  output logic                          timeout_err,
  output logic                          overrun_err
);

  localparam int W  = NBIT_DATA * NBYTES;
  localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [KW-1:0] K_LAST = KW'(NBYTES - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    RX_A    = 3'd0,
    RX_B    = 3'd1,
    RX_OP   = 3'd2,
    EXEC    = 3'd3,
    TX_SEND = 3'd4,
    TX_WAIT = 3'd5
  } state_t;

  state_t               state;
  logic [W-1:0]         shadow_a;
  logic [W-1:0]         shadow_b;
  logic [W-1:0]         result;
  logic [KW-1:0]        k;
  logic [TW-1:0]        tmo_cnt;
  logic [NBIT_DATA-1:0] tx_byte;
  logic                 tmo_run;
  logic                 tmo_hit;
  logic                 tx_phase;

  always_comb begin
    tx_byte = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (k == KW'(i)) tx_byte = result[i*NBIT_DATA +: NBIT_DATA];
    end
  end

  // An idle line between frames is not a timeout; the clock only runs once a frame has begun.
  assign tmo_run  = ((state == RX_A) && (k != '0)) || (state == RX_B) || (state == RX_OP);
  // A byte arriving on the expiry cycle takes priority over the timeout.
  assign tmo_hit  = tmo_run && (tmo_cnt == T_LAST) && !rx_done_tick;
  assign tx_phase = (state == EXEC) || (state == TX_SEND) || (state == TX_WAIT);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= RX_A;
      shadow_a    <= '0;
      shadow_b    <= '0;
      result      <= '0;
      A           <= '0;
      B           <= '0;
      OPCODE      <= '0;
      data_out    <= '0;
      tx_start    <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
      k           <= '0;
      tmo_cnt     <= '0;
    end else begin
      tx_start    <= 1'b0;
      timeout_err <= 1'b0;
      overrun_err <= rx_done_tick && tx_phase;

      if (rx_done_tick || !tmo_run || tmo_hit) tmo_cnt <= '0;
      else                                     tmo_cnt <= tmo_cnt + TW'(1);

      case (state)
        RX_A: begin
          if (rx_done_tick) begin
            for (int i = 0; i < NBYTES; i++) begin
              if (k == KW'(i)) shadow_a[i*NBIT_DATA +: NBIT_DATA] <= rx_data_in;
            end
            if (k == K_LAST) begin
              k     <= '0;
              state <= RX_B;
            end else begin
              k <= k + KW'(1);
            end
          end else if (tmo_hit) begin
            timeout_err <= 1'b1;
            k           <= '0;
          end
        end

        RX_B: begin
          if (rx_done_tick) begin
            for (int i = 0; i < NBYTES; i++) begin
              if (k == KW'(i)) shadow_b[i*NBIT_DATA +: NBIT_DATA] <= rx_data_in;
            end
            if (k == K_LAST) begin
              k     <= '0;
              state <= RX_OP;
            end else begin
              k <= k + KW'(1);
            end
          end else if (tmo_hit) begin
            timeout_err <= 1'b1;
            k           <= '0;
            state       <= RX_A;
          end
        end

        RX_OP: begin
          if (rx_done_tick) begin
            A      <= shadow_a;
            B      <= shadow_b;
            OPCODE <= rx_data_in[NBIT_OPCODE-1:0];
            busy   <= 1'b1;
            state  <= EXEC;
          end else if (tmo_hit) begin
            timeout_err <= 1'b1;
            k           <= '0;
            state       <= RX_A;
          end
        end

        EXEC: begin
          result <= alu_data_in;
          k      <= '0;
          state  <= TX_SEND;
        end

        TX_SEND: begin
          data_out <= tx_byte;
          tx_start <= 1'b1;
          state    <= TX_WAIT;
        end

        TX_WAIT: begin
          if (tx_done_tick) begin
            if (k != K_LAST) begin
              k     <= k + KW'(1);
              state <= TX_SEND;
            end else begin
              k     <= '0;
              busy  <= 1'b0;
              state <= RX_A;
            end
          end
        end

        default: begin
          k     <= '0;
          state <= RX_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_uart_frame_ctrl.sv
// Directed bench for alu_uart_frame_ctrl: a 2-byte instance with a short timeout and a
// 1-byte instance, each driven by a behavioural ADD/SUB ALU.
module tb_alu_uart_frame_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N;
  int          errors = 0;
  int          checks = 0;

  logic        rx_done, tx_done;
  logic [7:0]  rx_data;
  logic [15:0] alu_res, a, b;
  logic [5:0]  op;
  logic        tx_start, busy, tmo_err, ovr_err;
  logic [7:0]  data_out;

  logic        rx_done1, tx_done1;
  logic [7:0]  rx_data1, alu1, a1, b1, data_out1;
  logic [5:0]  op1;
  logic        tx_start1, busy1, tmo1, ovr1;

  int          n_tx = 0;
  int          n_tx1 = 0;
  int          n_tmo = 0;

  always #5 CLK = ~CLK;

  alu_uart_frame_ctrl #(.NBIT_DATA(8), .NBYTES(2), .NBIT_OPCODE(6), .TIMEOUT_CYCLES(50)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .rx_done_tick(rx_done), .rx_data_in(rx_data),
    .tx_done_tick(tx_done), .alu_data_in(alu_res), .A(a), .B(b), .OPCODE(op),
    .tx_start(tx_start), .data_out(data_out), .busy(busy),
    .timeout_err(tmo_err), .overrun_err(ovr_err)
  );

  alu_uart_frame_ctrl #(.NBIT_DATA(8), .NBYTES(1), .NBIT_OPCODE(6), .TIMEOUT_CYCLES(50)) u_dut1 (
    .CLK(CLK), .RST_N(RST_N), .rx_done_tick(rx_done1), .rx_data_in(rx_data1),
    .tx_done_tick(tx_done1), .alu_data_in(alu1), .A(a1), .B(b1), .OPCODE(op1),
    .tx_start(tx_start1), .data_out(data_out1), .busy(busy1),
    .timeout_err(tmo1), .overrun_err(ovr1)
  );

  always_comb begin
    case (op)
      6'h20:   alu_res = a + b;
      6'h22:   alu_res = a - b;
      default: alu_res = '0;
    endcase
    case (op1)
      6'h20:   alu1 = a1 + b1;
      6'h22:   alu1 = a1 - b1;
      default: alu1 = '0;
    endcase
  end

  always @(posedge CLK) begin
    if (tx_start)  n_tx++;
    if (tx_start1) n_tx1++;
    if (tmo_err)   n_tmo++;
  end

  // Stimulus tasks are entered and left on a falling edge.
  task automatic send_byte(input logic [7:0] v);
    rx_data = v;
    rx_done = 1'b1;
    @(negedge CLK);
    rx_done = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b0, b1_, b2, b3, b4);
    send_byte(b0); send_byte(b1_); send_byte(b2); send_byte(b3); send_byte(b4);
  endtask

  task automatic pulse_tx();
    tx_done = 1'b1;
    @(negedge CLK);
    tx_done = 1'b0;
  endtask

  task automatic wait_tx(output bit ok, output logic [7:0] v);
    ok = 1'b0;
    v  = '0;
    repeat (20) begin
      if (!ok) begin
        if (tx_start) begin
          ok = 1'b1;
          v  = data_out;
        end else begin
          @(negedge CLK);
        end
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if (a !== 16'h0 || b !== 16'h0 || op !== 6'h0 || data_out !== 8'h0) begin
      errors++;
      $display("FAIL reset_data: A=%h B=%h OP=%h data_out=%h, want all 0", a, b, op, data_out);
    end
    checks++;
    if (tx_start !== 1'b0 || busy !== 1'b0 || tmo_err !== 1'b0 || ovr_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: tx_start=%b busy=%b tmo=%b ovr=%b, want 0", tx_start, busy, tmo_err, ovr_err);
    end
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if (tx_start !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: tx_start=%b busy=%b, want 0 0", tx_start, busy);
    end
  endtask

  task automatic test_frame_add();
    bit ok;
    logic [7:0] v;
    send_frame(8'h34, 8'h12, 8'h11, 8'h00, 8'h20);
    checks++;
    if (a !== 16'h1234 || b !== 16'h0011 || op !== 6'h20 || busy !== 1'b1) begin
      errors++;
      $display("FAIL commit: A=%h B=%h OP=%h busy=%b, want 1234 0011 20 1", a, b, op, busy);
    end
    checks++;
    if (tx_start !== 1'b0) begin
      errors++;
      $display("FAIL latency_t1: tx_start=%b, want 0", tx_start);
    end
    @(negedge CLK);
    checks++;
    if (tx_start !== 1'b0) begin
      errors++;
      $display("FAIL latency_t2: tx_start=%b, want 0", tx_start);
    end
    @(negedge CLK);
    checks++;
    if (tx_start !== 1'b1 || data_out !== 8'h45) begin
      errors++;
      $display("FAIL first_byte: tx_start=%b data_out=%h, want 1 45", tx_start, data_out);
    end
    repeat (3) @(negedge CLK);
    checks++;
    if (n_tx !== 1 || data_out !== 8'h45) begin
      errors++;
      $display("FAIL hold_byte: tx_starts=%0d data_out=%h, want 1 45", n_tx, data_out);
    end
    pulse_tx();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_mid: busy=%b, want 1", busy);
    end
    wait_tx(ok, v);
    checks++;
    if (!ok || v !== 8'h12) begin
      errors++;
      $display("FAIL second_byte: seen=%b data_out=%h, want 1 12", ok, v);
    end
    pulse_tx();
    checks++;
    if (busy !== 1'b0 || n_tx !== 2) begin
      errors++;
      $display("FAIL busy_end: busy=%b tx_starts=%0d, want 0 2", busy, n_tx);
    end
  endtask

  task automatic test_timeout();
    bit early = 1'b0;
    bit ok0, ok1;
    logic [7:0] v0, v1;
    send_byte(8'h01);
    for (int n = 1; n < 50; n++) begin
      @(negedge CLK);
      if (tmo_err !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early) begin
      errors++;
      $display("FAIL timeout_early: timeout_err rose before cycle 50, want 0");
    end
    @(negedge CLK);
    checks++;
    if (tmo_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_pulse: timeout_err=%b at cycle 50, want 1", tmo_err);
    end
    @(negedge CLK);
    checks++;
    if (tmo_err !== 1'b0 || a !== 16'h1234) begin
      errors++;
      $display("FAIL timeout_after: timeout_err=%b A=%h, want 0 1234", tmo_err, a);
    end
    send_frame(8'hFF, 8'hFF, 8'h01, 8'h00, 8'h20);
    checks++;
    if (a !== 16'hFFFF || b !== 16'h0001) begin
      errors++;
      $display("FAIL wrap_commit: A=%h B=%h, want ffff 0001", a, b);
    end
    wait_tx(ok0, v0);
    pulse_tx();
    wait_tx(ok1, v1);
    pulse_tx();
    checks++;
    if (!ok0 || !ok1 || v0 !== 8'h00 || v1 !== 8'h00) begin
      errors++;
      $display("FAIL wrap_tx: seen=%b%b bytes=%h %h, want 00 00", ok0, ok1, v0, v1);
    end
  endtask

  task automatic test_expiry_edge();
    bit ok0, ok1;
    logic [7:0] v0, v1;
    int tmo_before;
    tmo_before = n_tmo;
    send_byte(8'h78);
    repeat (49) @(negedge CLK);
    send_byte(8'h56);
    checks++;
    if (tmo_err !== 1'b0) begin
      errors++;
      $display("FAIL expiry_no_tmo: timeout_err=%b, want 0", tmo_err);
    end
    send_frame(8'h02, 8'h00, 8'h20, 8'h00, 8'h00);
    checks++;
    if (a !== 16'h5678 || b !== 16'h0002 || op !== 6'h20 || n_tmo !== tmo_before) begin
      errors++;
      $display("FAIL expiry_commit: A=%h B=%h OP=%h timeouts=%0d, want 5678 0002 20 %0d",
               a, b, op, n_tmo, tmo_before);
    end
    wait_tx(ok0, v0);
    pulse_tx();
    wait_tx(ok1, v1);
    pulse_tx();
    checks++;
    if (!ok0 || !ok1 || v0 !== 8'h7A || v1 !== 8'h56) begin
      errors++;
      $display("FAIL expiry_tx: bytes=%h %h, want 7a 56", v0, v1);
    end
  endtask

  task automatic test_overrun();
    bit ok0, ok1, ok2, ok3;
    logic [7:0] v0, v1, v2, v3;
    send_frame(8'h10, 8'h00, 8'h05, 8'h00, 8'h20);
    wait_tx(ok0, v0);
    send_byte(8'hAA);
    checks++;
    if (ovr_err !== 1'b1 || a !== 16'h0010 || b !== 16'h0005) begin
      errors++;
      $display("FAIL overrun_pulse: ovr=%b A=%h B=%h, want 1 0010 0005", ovr_err, a, b);
    end
    @(negedge CLK);
    checks++;
    if (ovr_err !== 1'b0 || data_out !== 8'h15) begin
      errors++;
      $display("FAIL overrun_clear: ovr=%b data_out=%h, want 0 15", ovr_err, data_out);
    end
    pulse_tx();
    wait_tx(ok1, v1);
    rx_data = 8'hAA;
    rx_done = 1'b1;
    tx_done = 1'b1;
    @(negedge CLK);
    rx_done = 1'b0;
    tx_done = 1'b0;
    checks++;
    if (ovr_err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL overrun_with_done: ovr=%b busy=%b, want 1 0", ovr_err, busy);
    end
    checks++;
    if (!ok0 || !ok1 || v0 !== 8'h15 || v1 !== 8'h00) begin
      errors++;
      $display("FAIL overrun_tx: bytes=%h %h, want 15 00", v0, v1);
    end
    @(negedge CLK);
    send_frame(8'h03, 8'h00, 8'h04, 8'h00, 8'h20);
    checks++;
    if (a !== 16'h0003 || b !== 16'h0004) begin
      errors++;
      $display("FAIL overrun_next: A=%h B=%h, want 0003 0004", a, b);
    end
    wait_tx(ok2, v2);
    pulse_tx();
    wait_tx(ok3, v3);
    pulse_tx();
    checks++;
    if (!ok2 || !ok3 || v2 !== 8'h07 || v3 !== 8'h00) begin
      errors++;
      $display("FAIL overrun_next_tx: bytes=%h %h, want 07 00", v2, v3);
    end
  endtask

  task automatic test_reset_mid_tx();
    bit ok0, ok1, ok2;
    logic [7:0] v0, v1, v2;
    int tx_before;
    send_frame(8'h01, 8'h00, 8'h02, 8'h00, 8'h20);
    wait_tx(ok0, v0);
    pulse_tx();
    RST_N = 1'b0;
    #1;
    checks++;
    if (a !== 16'h0 || b !== 16'h0 || op !== 6'h0 || data_out !== 8'h0 || busy !== 1'b0 || tx_start !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: A=%h B=%h OP=%h data_out=%h busy=%b tx_start=%b, want all 0",
               a, b, op, data_out, busy, tx_start);
    end
    tx_before = n_tx;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (4) @(negedge CLK);
    checks++;
    if (n_tx !== tx_before || !ok0 || v0 !== 8'h03) begin
      errors++;
      $display("FAIL mid_reset_quiet: tx_starts=%0d first=%h, want %0d 03", n_tx, v0, tx_before);
    end
    send_frame(8'h02, 8'h00, 8'h03, 8'h00, 8'h20);
    wait_tx(ok1, v1);
    pulse_tx();
    wait_tx(ok2, v2);
    pulse_tx();
    checks++;
    if (!ok1 || !ok2 || v1 !== 8'h05 || v2 !== 8'h00) begin
      errors++;
      $display("FAIL post_reset_tx: bytes=%h %h, want 05 00", v1, v2);
    end
  endtask

  task automatic test_nbytes1();
    bit ok = 1'b0;
    logic [7:0] v = '0;
    rx_data1 = 8'h05; rx_done1 = 1'b1; @(negedge CLK);
    rx_data1 = 8'h03; @(negedge CLK);
    rx_data1 = 8'h22; @(negedge CLK);
    rx_done1 = 1'b0;
    checks++;
    if (a1 !== 8'h05 || b1 !== 8'h03 || op1 !== 6'h22 || busy1 !== 1'b1) begin
      errors++;
      $display("FAIL nb1_commit: A=%h B=%h OP=%h busy=%b, want 05 03 22 1", a1, b1, op1, busy1);
    end
    repeat (20) begin
      if (!ok) begin
        if (tx_start1) begin
          ok = 1'b1;
          v  = data_out1;
        end else begin
          @(negedge CLK);
        end
      end
    end
    tx_done1 = 1'b1;
    @(negedge CLK);
    tx_done1 = 1'b0;
    repeat (4) @(negedge CLK);
    checks++;
    if (!ok || v !== 8'h02 || n_tx1 !== 1 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL nb1_tx: seen=%b byte=%h tx_starts=%0d busy=%b, want 1 02 1 0", ok, v, n_tx1, busy1);
    end
  endtask

  initial begin
    RST_N    = 1'b0;
    rx_done  = 1'b0; rx_data  = '0; tx_done  = 1'b0;
    rx_done1 = 1'b0; rx_data1 = '0; tx_done1 = 1'b0;
    repeat (3) @(negedge CLK);
    test_reset();
    test_frame_add();
    test_timeout();
    test_expiry_edge();
    test_overrun();
    test_reset_mid_tx();
    test_nbytes1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
